// File: rtl/key_schedule_seq.sv
// rtl/key_schedule_seq.sv - sequential multi-slot CSA block-cipher key schedule
// One 64-bit round per clock through a shared key_perm; results commit atomically into a slot.
module key_schedule_seq #(
    parameter int NKEYS  = 2,
    parameter int SLOT_W = 1,
    parameter int ROUNDS = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [63:0]          i_ck,
    input  logic [SLOT_W-1:0]    i_slot,
    input  logic [SLOT_W-1:0]    i_sel,
    input  logic                 i_clr,
    output logic [ROUNDS*64-1:0] o_kk,
    output logic                 o_kk_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_drop
);
    localparam int KKW = ROUNDS * 64;
    localparam int RW  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    // 1-based destination of each source bit; bits are numbered MSB-first within each byte
    localparam logic [6:0] KEY_PERM [64] = '{
        7'h12, 7'h24, 7'h09, 7'h07, 7'h2A, 7'h31, 7'h1D, 7'h15,
        7'h1C, 7'h36, 7'h3E, 7'h32, 7'h13, 7'h21, 7'h3B, 7'h40,
        7'h18, 7'h14, 7'h25, 7'h27, 7'h02, 7'h35, 7'h1B, 7'h01,
        7'h22, 7'h04, 7'h0D, 7'h0E, 7'h39, 7'h28, 7'h1A, 7'h29,
        7'h33, 7'h23, 7'h34, 7'h0C, 7'h16, 7'h30, 7'h1E, 7'h3A,
        7'h2D, 7'h1F, 7'h08, 7'h19, 7'h17, 7'h2F, 7'h3D, 7'h11,
        7'h3C, 7'h05, 7'h38, 7'h2B, 7'h0B, 7'h06, 7'h0A, 7'h2C,
        7'h20, 7'h3F, 7'h2E, 7'h0F, 7'h03, 7'h26, 7'h10, 7'h37
    };

    function automatic logic [5:0] hw_bit(input logic [5:0] n);
        return {n[5:3], ~n[2:0]};
    endfunction

    function automatic logic [63:0] key_perm(input logic [63:0] kb);
        logic [63:0] res;
        logic [5:0]  dst;
        res = '0;
        for (int n = 0; n < 64; n++) begin
            dst = 6'(KEY_PERM[n] - 7'd1);
            res[hw_bit(dst)] = kb[hw_bit(6'(n))];
        end
        return res;
    endfunction

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [RW-1:0]      r_q, r_d;
    logic [63:0]        kb_q, kb_d;
    logic [KKW-1:0]     kk_q, kk_d;
    logic [SLOT_W-1:0]  tslot_q, tslot_d;
    logic               done_q, done_d;
    logic               drop_q, drop_d;
    logic               commit;
    logic [7:0]         rc;

    logic [KKW-1:0]     slot_q [NKEYS];
    logic [NKEYS-1:0]   valid_q;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        kb_d    = kb_q;
        kk_d    = kk_q;
        tslot_d = tslot_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        commit  = 1'b0;
        rc      = 8'(r_q);
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    kb_d    = i_ck;
                    r_d     = RW'(ROUNDS - 1);
                    tslot_d = i_slot;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < ROUNDS; i++) begin
                    if (r_q == RW'(i)) begin
                        kk_d[i*64 +: 64] = kb_q ^ {8{rc}};
                    end
                end
                kb_d   = key_perm(kb_q);
                r_d    = r_q - RW'(1);
                drop_d = i_start;
                // kk_d already holds the round-0 bytes, so the slot gets the complete key
                if (r_q == '0) begin
                    commit  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            kb_q    <= '0;
            kk_q    <= '0;
            tslot_q <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            kb_q    <= kb_d;
            kk_q    <= kk_d;
            tslot_q <= tslot_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    // A commit outranks a simultaneous clear for the slot being written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NKEYS; k++) begin
                slot_q[k] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int k = 0; k < NKEYS; k++) begin
                if (commit && (tslot_q == SLOT_W'(k))) begin
                    slot_q[k]  <= kk_d;
                    valid_q[k] <= 1'b1;
                end else if (i_clr) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        o_kk       = '0;
        o_kk_valid = 1'b0;
        for (int k = 0; k < NKEYS; k++) begin
            if (i_sel == SLOT_W'(k)) begin
                o_kk       = slot_q[k];
                o_kk_valid = valid_q[k];
            end
        end
    end

    assign o_busy = (state_q == S_RUN);
    assign o_done = done_q;
    assign o_drop = drop_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
// tb/tb_key_schedule_seq.sv - scoreboard bench for key_schedule_seq
module tb_key_schedule_seq;
    localparam int NKEYS  = 2;
    localparam int SLOT_W = 2;
    localparam int ROUNDS = 7;
    localparam int KKW    = ROUNDS * 64;

    localparam int KP [64] = '{
        18, 36,  9,  7, 42, 49, 29, 21, 28, 54, 62, 50, 19, 33, 59, 64,
        24, 20, 37, 39,  2, 53, 27,  1, 34,  4, 13, 14, 57, 40, 26, 41,
        51, 35, 52, 12, 22, 48, 30, 58, 45, 31,  8, 25, 23, 47, 61, 17,
        60,  5, 56, 43, 11,  6, 10, 44, 32, 63, 46, 15,  3, 38, 16, 55
    };

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic [63:0]       i_ck = '0;
    logic [SLOT_W-1:0] i_slot = '0;
    logic [SLOT_W-1:0] i_sel = '0;
    logic              i_clr = 1'b0;
    logic [KKW-1:0]    o_kk;
    logic              o_kk_valid;
    logic              o_busy;
    logic              o_done;
    logic              o_drop;

    key_schedule_seq #(.NKEYS(NKEYS), .SLOT_W(SLOT_W), .ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_ck(i_ck), .i_slot(i_slot),
        .i_sel(i_sel), .i_clr(i_clr), .o_kk(o_kk), .o_kk_valid(o_kk_valid),
        .o_busy(o_busy), .o_done(o_done), .o_drop(o_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [KKW-1:0] kk;
        int             due;
    } exp_t;

    exp_t done_q[$];
    int   drop_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t mon_e;
    int   mon_d;

    task automatic check_kk(input string name, input logic [KKW-1:0] act, input logic [KKW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Closed form for a constant-byte control word: the permutation keeps uniform words uniform
    function automatic logic [KKW-1:0] flat_kk(input logic [7:0] b);
        logic [KKW-1:0] r;
        for (int i = 0; i < ROUNDS; i++)
            for (int j = 0; j < 8; j++)
                r[(8*i+j)*8 +: 8] = b ^ 8'(i);
        return r;
    endfunction

    // ck = 64'h80: the single set bit traced by hand through six permutations
    function automatic logic [KKW-1:0] bit_kk();
        logic [KKW-1:0] r;
        r = flat_kk(8'h00);
        r[48*8 +: 8] = 8'h86;
        r[42*8 +: 8] = 8'h45;
        r[34*8 +: 8] = 8'h14;
        r[28*8 +: 8] = 8'h01;
        r[19*8 +: 8] = 8'h06;
        r[12*8 +: 8] = 8'h00;
        r[ 7*8 +: 8] = 8'h40;
        return r;
    endfunction

    function automatic logic [KKW-1:0] ref_schedule(input logic [63:0] ck);
        logic [7:0]     kb [8][8];
        logic           bitv [64];
        logic           newbit [64];
        logic [KKW-1:0] kk;
        for (int j = 0; j < 8; j++) kb[7][j] = ck[8*j +: 8];
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 8; j++)
                for (int k = 0; k < 8; k++) begin
                    bitv[j*8+k] = kb[7-i][j][7-k];
                    newbit[KP[j*8+k]-1] = bitv[j*8+k];
                end
            for (int j = 0; j < 8; j++)
                for (int k = 0; k < 8; k++)
                    kb[6-i][j][7-k] = newbit[j*8+k];
        end
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 8; j++)
                kk[(8*i+j)*8 +: 8] = kb[1+i][j] ^ 8'(i);
        return kk;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst_n && o_done) begin
            if (done_q.size() == 0) begin
                check_int("unexpected_done", int'(o_done), 0);
            end else begin
                mon_e = done_q.pop_front();
                check_int("done_latency", cyc, mon_e.due);
                check_kk("done_kk", o_kk, mon_e.kk);
                check_int("done_valid", int'(o_kk_valid), 1);
                check_int("done_busy", int'(o_busy), 0);
            end
        end
        if (rst_n && o_drop) begin
            if (drop_q.size() == 0) begin
                check_int("unexpected_drop", int'(o_drop), 0);
            end else begin
                mon_d = drop_q.pop_front();
                check_int("drop_latency", cyc, mon_d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input logic [63:0] ck, input logic [SLOT_W-1:0] slot, input logic [KKW-1:0] kk);
        exp_t e;
        i_start = 1'b1;
        i_ck    = ck;
        i_slot  = slot;
        i_sel   = slot;
        e.kk    = kk;
        e.due   = cyc + ROUNDS + 1;
        done_q.push_back(e);
        tick();
        i_start = 1'b0;
        i_ck    = 64'hDEAD_BEEF_5A5A_A5A5;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40 && done_q.size() != 0; i++) tick();
        check_int(name, done_q.size(), 0);
        done_q.delete();
    endtask

    logic [KKW-1:0] model_kk;

    initial begin
        model_kk = ref_schedule(64'h0123_4567_89AB_CDEF);
        #3;
        check_kk("reset_kk0", o_kk, '0);
        check_int("reset_valid0", int'(o_kk_valid), 0);
        check_int("reset_busy", int'(o_busy), 0);
        check_int("reset_done", int'(o_done), 0);
        check_int("reset_drop", int'(o_drop), 0);
        i_sel = 2'd1;
        #1;
        check_kk("reset_kk1", o_kk, '0);
        check_int("reset_valid1", int'(o_kk_valid), 0);
        tick();
        rst_n = 1'b1;
        tick();

        start(64'h0, 2'd0, flat_kk(8'h00));
        check_int("busy_running", int'(o_busy), 1);
        wait_done("zero_key_done");

        start(64'hFFFF_FFFF_FFFF_FFFF, 2'd1, flat_kk(8'hFF));
        wait_done("ones_key_done");
        i_sel = 2'd0;
        #1;
        check_kk("slot0_kept", o_kk, flat_kk(8'h00));
        check_int("slot0_valid", int'(o_kk_valid), 1);

        start(64'h0123_4567_89AB_CDEF, 2'd1, model_kk);
        for (int i = 0; i < ROUNDS; i++) begin
            check_kk("old_key_during_run", o_kk, flat_kk(8'hFF));
            check_int("old_valid_during_run", int'(o_kk_valid), 1);
            tick();
        end
        wait_done("model_key_done");

        start(64'h80, 2'd0, bit_kk());
        tick();
        tick();
        i_start = 1'b1;
        i_ck    = 64'hFFFF_FFFF_FFFF_FFFF;
        i_slot  = 2'd1;
        drop_q.push_back(cyc + 1);
        tick();
        i_start = 1'b0;
        wait_done("drop_run_done");
        i_sel = 2'd1;
        #1;
        check_kk("drop_slot1_untouched", o_kk, model_kk);

        start(64'hFFFF_FFFF_FFFF_FFFF, 2'd0, flat_kk(8'hFF));
        repeat (ROUNDS) tick();
        check_int("b2b_done_cycle", int'(o_done), 1);
        start(64'h80, 2'd1, bit_kk());
        wait_done("b2b_done");

        start(64'h0, 2'd1, flat_kk(8'h00));
        repeat (3) tick();
        rst_n = 1'b0;
        done_q.delete();
        #1;
        check_int("abort_busy", int'(o_busy), 0);
        check_int("abort_done", int'(o_done), 0);
        check_int("abort_drop", int'(o_drop), 0);
        check_kk("abort_kk1", o_kk, '0);
        check_int("abort_valid1", int'(o_kk_valid), 0);
        i_sel = 2'd0;
        #1;
        check_int("abort_valid0", int'(o_kk_valid), 0);
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        i_sel = 2'd1;
        #1;
        check_int("abort_slot1_invalid", int'(o_kk_valid), 0);

        start(64'h0123_4567_89AB_CDEF, 2'd0, model_kk);
        wait_done("clr_prep_done");
        start(64'hFFFF_FFFF_FFFF_FFFF, 2'd1, flat_kk(8'hFF));
        repeat (ROUNDS - 1) tick();
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        check_int("clr_commit_valid", int'(o_kk_valid), 1);
        i_sel = 2'd0;
        #1;
        check_int("clr_other_invalid", int'(o_kk_valid), 0);
        check_kk("clr_data_retained", o_kk, model_kk);
        i_sel = 2'd2;
        #1;
        check_kk("sel_oor_kk", o_kk, '0);
        check_int("sel_oor_valid", int'(o_kk_valid), 0);
        wait_done("clr_done");

        repeat (3) tick();
        check_int("scoreboard_empty", done_q.size() + drop_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/key_schedule_seq.md
Name: key_schedule_seq

Overview:
Sequential, multi-slot successor to the combinational CSA key schedule. Expands a 64-bit control word (CK) into the ROUNDS*8-byte block-cipher key (KK), one 64-bit round per clock, through a single shared instance of the 64-bit CSA key bit-permutation (`key_perm`).
Results are committed atomically into one of NKEYS key slots, for example even/odd keys. The block cipher reads any slot at any time, and never sees a partially updated key.

Parameters:
NKEYS, 2, number of key slots (must be >= 2)
SLOT_W, 1, slot index width (must be >= clog2(NKEYS))
ROUNDS, 7, number of key rounds; the KK width is ROUNDS*64 bits (7 gives 56 bytes)

Ports:
clk  input  1  clock, all flops rising-edge
rst_n  input  1  asynchronous active-low reset
i_start  input  1  request a key expansion; sampled each rising edge
i_ck  input  64  control word; byte j at bits [8j+7:8j]; sampled only with an accepted i_start
i_slot  input  SLOT_W  destination slot; sampled with an accepted i_start
i_sel  input  SLOT_W  slot to present on o_kk
i_clr  input  1  invalidate all slots
o_kk  output  ROUNDS*64  KK of slot i_sel; byte k at bits [8k+7:8k]
o_kk_valid  output  1  valid flag of slot i_sel
o_busy  output  1  expansion in progress
o_done  output  1  one-cycle pulse: slot committed
o_drop  output  1  one-cycle pulse: i_start ignored

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - Round counter r, working kb, working kk and all slot storage are cleared to 0.
  - All valid flags, o_busy, o_done and o_drop are 0.
  - o_kk reads 0.
- Reset mid-RUN aborts the expansion: no commit, and no slot changes.
- FSM has two states, IDLE and RUN.
- IDLE, edge with i_start=1:
  - kb <= i_ck, r <= ROUNDS-1, latch i_slot.
  - Go to RUN; o_busy=1 from the next cycle.
- RUN, each edge:
  - Round bytes r*8..r*8+7 of working kk <= kb XOR {8{r[7:0]}}, i.e. every byte XOR the round number.
  - kb <= key_perm(kb); r <= r-1.
- RUN, edge with r==0 (the ROUNDS-th RUN edge):
  - The full working kk, including the round-0 bytes written this edge, is written into the latched slot.
  - That slot's valid flag is set to 1.
  - o_done=1 for the next cycle only; o_busy=0; go to IDLE.
- Latency:
  - i_start sampled at edge E0 gives o_done high after edge E0+ROUNDS (7 edges).
  - Updated o_kk is visible in the same cycle as o_done.
  - Throughput is one key per ROUNDS+1 cycles: i_start may be accepted in the o_done cycle.
- i_start while in RUN:
  - Ignored; i_ck and i_slot are not sampled.
  - o_drop=1 for the next cycle.
  - The in-flight expansion is unaffected.
- The destination slot keeps its old contents and valid flag until the commit edge, so an old key can still be read during the update.
- i_clr=1 at an edge clears every valid flag; slot data is retained.
  - If the same edge is a commit edge, the commit wins for the committed slot: its flag ends at 1 and all other flags end at 0.
- i_clr does not affect RUN.
- o_kk and o_kk_valid are combinational muxes from i_sel.
- i_sel >= NKEYS gives o_kk=0 and o_kk_valid=0.
- i_slot >= NKEYS at start: the expansion runs, commit writes nothing, o_done still pulses.
- Round constant uses the low 8 bits of r; round 0 XORs 0x00.

Test Plan:
- Reset, then start with i_ck=0, i_slot=0:
  - Exactly 7 cycles later, o_done=1 for one cycle.
  - With i_sel=0: kk bytes 0-7=0x00, 8-15=0x01, ..., 48-55=0x06 (the permutation maps 0 to 0); o_kk_valid=1.
- Start with i_ck=64'hFFFF_FFFF_FFFF_FFFF, slot 1:
  - Slot 1 bytes 0-7=0xFF, 8-15=0xFE, ..., 48-55=0xF9.
  - Slot 0 is unchanged from the previous test.
- Random i_ck into slot 1: compare against the combinational key_schedule model.
  - While RUN, i_sel=1 still shows the old slot-1 KK until the o_done cycle.
- i_start pulse 3 cycles into RUN:
  - o_drop=1 for one cycle.
  - The original result is committed at the original 7-cycle latency; only one o_done.
- Back-to-back: a start in the o_done cycle is accepted; its o_done follows 7 cycles later with no o_drop.
- rst_n=0 at the 4th RUN cycle: all outputs are 0 immediately (async), no o_done afterwards, slots invalid.
- i_clr asserted in the commit cycle:
  - The committed slot stays valid and other slots become invalid.
  - i_sel=2 (out of range for NKEYS=2) gives o_kk=0 and o_kk_valid=0.
